// File: rtl/fifo_pkg.sv
// Shared defaults and helper constants for the single-clock byte FIFO.
// Names carry a FIFO_ prefix so modules can override them with same-named parameters.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = 8;
   localparam int unsigned FIFO_DEPTH      = 64;
   localparam int unsigned FIFO_ADDR_WIDTH = 6;
   localparam int unsigned FIFO_CNT_WIDTH  = 8;

   // Occupancy value at which the default-sized FIFO reports full.
   localparam logic [FIFO_CNT_WIDTH-1:0] FIFO_FULL_CNT = FIFO_CNT_WIDTH'(FIFO_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write port and a registered read port.
// Only the read register is reset; the array itself keeps its contents.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO_DEPTH,
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data holds its last value when no read is accepted.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_q[raddr_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo.sv
// Single-clock byte FIFO: circular buffer with pointers, occupancy counter and
// full/empty flags decoded combinationally from the counter.
module fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH      = FIFO_DEPTH,
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int unsigned CNT_WIDTH  = FIFO_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] buf_in,
   output logic [DATA_WIDTH-1:0] buf_out,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic                  buf_empty,
   output logic                  buf_full,
   output logic [CNT_WIDTH-1:0]  fifo_counter
);

   localparam logic [CNT_WIDTH-1:0] FullCnt = CNT_WIDTH'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
   logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
   logic                  wr_acc, rd_acc;

   assign buf_empty    = (cnt_q == '0);
   assign buf_full     = (cnt_q == FullCnt);
   assign fifo_counter = cnt_q;

   // Gating by the flags keeps the counter in range and blocks reads of unwritten entries.
   assign wr_acc = wr_en & ~buf_full;
   assign rd_acc = rd_en & ~buf_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
         2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (clk),
      .rst_ni  (rst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (buf_in),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (buf_out)
   );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a queue-based scoreboard tracks expected read data
// and occupancy; each scenario task compares DUT outputs against it.
module tb_fifo;
   import fifo_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] buf_in;
   logic [7:0] buf_out;
   logic       wr_en;
   logic       rd_en;
   logic       buf_empty;
   logic       buf_full;
   logic [7:0] fifo_counter;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         model_cnt = 0;
   logic [7:0] exp_out = 8'd0;

   fifo dut (
      .clk          (clk),
      .rst          (rst),
      .buf_in       (buf_in),
      .buf_out      (buf_out),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .buf_empty    (buf_empty),
      .buf_full     (buf_full),
      .fifo_counter (fifo_counter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus, then update the scoreboard for what should have been accepted.
   task automatic step(input logic w, input logic r, input logic [7:0] d);
      logic wa, ra;
      wa     = w && (model_cnt < 64);
      ra     = r && (model_cnt > 0);
      wr_en  = w;
      rd_en  = r;
      buf_in = d;
      @(posedge clk);
      #1;
      if (ra) exp_out = exp_q.pop_front();
      if (wa) exp_q.push_back(d);
      model_cnt = model_cnt + int'(wa) - int'(ra);
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   // Pulse reset between clock edges and clear the scoreboard.
   task automatic apply_reset();
      wr_en = 1'b0;
      rd_en = 1'b0;
      rst   = 1'b0;
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      exp_out   = 8'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      rst    = 1'b0;
      wr_en  = 1'b1;
      rd_en  = 1'b1;
      buf_in = 8'h3C;
      #2;
      checks++;
      if (fifo_counter !== 8'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", fifo_counter);
      end
      checks++;
      if (buf_empty !== 1'b1) begin
         errors++; $display("FAIL reset_empty: got %b expected 1", buf_empty);
      end
      checks++;
      if (buf_full !== 1'b0) begin
         errors++; $display("FAIL reset_full: got %b expected 0", buf_full);
      end
      checks++;
      if (buf_out !== 8'd0) begin
         errors++; $display("FAIL reset_out: got %0d expected 0", buf_out);
      end
      // Held reset must win over a clock edge with both enables high.
      @(posedge clk);
      #1;
      checks++;
      if (fifo_counter !== 8'd0 || buf_empty !== 1'b1) begin
         errors++; $display("FAIL reset_held: got cnt=%0d empty=%b expected cnt=0 empty=1",
                            fifo_counter, buf_empty);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic test_ordered();
      logic [7:0] vals [4];
      vals = '{8'd100, 8'd150, 8'd175, 8'd200};
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, vals[i]);
      checks++;
      if (fifo_counter !== 8'd4 || buf_empty !== 1'b0) begin
         errors++; $display("FAIL ordered_fill: got cnt=%0d empty=%b expected cnt=4 empty=0",
                            fifo_counter, buf_empty);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'd0);
         checks++;
         if (buf_out !== exp_out || buf_out !== vals[i]) begin
            errors++; $display("FAIL ordered_read%0d: got %0d expected %0d", i, buf_out, vals[i]);
         end
      end
      checks++;
      if (fifo_counter !== 8'd0 || buf_empty !== 1'b1) begin
         errors++; $display("FAIL ordered_drain: got cnt=%0d empty=%b expected cnt=0 empty=1",
                            fifo_counter, buf_empty);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 8'(i));
      checks++;
      if (buf_full !== 1'b1 || fifo_counter !== FIFO_FULL_CNT) begin
         errors++; $display("FAIL fill_full: got full=%b cnt=%0d expected full=1 cnt=64",
                            buf_full, fifo_counter);
      end
      step(1'b1, 1'b0, 8'hAA);
      checks++;
      if (fifo_counter !== 8'd64) begin
         errors++; $display("FAIL fill_overflow: got %0d expected 64", fifo_counter);
      end
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 1'b1, 8'd0);
         checks++;
         if (buf_out !== exp_out) begin
            errors++; $display("FAIL fill_drain%0d: got %0d expected %0d", i, buf_out, exp_out);
         end
      end
      checks++;
      if (buf_empty !== 1'b1 || fifo_counter !== 8'd0) begin
         errors++; $display("FAIL fill_end: got empty=%b cnt=%0d expected empty=1 cnt=0",
                            buf_empty, fifo_counter);
      end
   endtask

   task automatic test_read_empty();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'd0);
         checks++;
         if (buf_out !== 8'd0 || fifo_counter !== 8'd0) begin
            errors++; $display("FAIL empty_read%0d: got out=%0d cnt=%0d expected out=0 cnt=0",
                               i, buf_out, fifo_counter);
         end
      end
      step(1'b1, 1'b0, 8'd225);
      step(1'b0, 1'b1, 8'd0);
      checks++;
      if (buf_out !== 8'd225 || fifo_counter !== 8'd0) begin
         errors++; $display("FAIL empty_then_write: got out=%0d cnt=%0d expected out=225 cnt=0",
                            buf_out, fifo_counter);
      end
   endtask

   task automatic test_simultaneous();
      step(1'b1, 1'b0, 8'd11);
      step(1'b1, 1'b0, 8'd22);
      step(1'b1, 1'b1, 8'd33);
      checks++;
      if (fifo_counter !== 8'd2 || buf_out !== exp_out) begin
         errors++; $display("FAIL simul_mid: got cnt=%0d out=%0d expected cnt=2 out=%0d",
                            fifo_counter, buf_out, exp_out);
      end
      while (model_cnt > 0) step(1'b0, 1'b1, 8'd0);
      checks++;
      if (buf_out !== 8'd33) begin
         errors++; $display("FAIL simul_drain: got %0d expected 33", buf_out);
      end
      step(1'b1, 1'b1, 8'd44);
      checks++;
      if (fifo_counter !== 8'd1 || buf_out !== 8'd33) begin
         errors++; $display("FAIL simul_empty: got cnt=%0d out=%0d expected cnt=1 out=33",
                            fifo_counter, buf_out);
      end
      while (model_cnt < 64) step(1'b1, 1'b0, 8'(model_cnt * 3));
      step(1'b1, 1'b1, 8'hEE);
      checks++;
      if (fifo_counter !== 8'd63 || buf_full !== 1'b0 || buf_out !== exp_out) begin
         errors++; $display("FAIL simul_full: got cnt=%0d out=%0d expected cnt=63 out=%0d",
                            fifo_counter, buf_out, exp_out);
      end
      while (model_cnt > 0) begin
         step(1'b0, 1'b1, 8'd0);
         checks++;
         if (buf_out !== exp_out) begin
            errors++; $display("FAIL simul_full_drain: got %0d expected %0d", buf_out, exp_out);
         end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 100; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         checks++;
         if (buf_out !== exp_out || fifo_counter !== 8'(model_cnt)) begin
            errors++; $display("FAIL wrap%0d: got out=%0d cnt=%0d expected out=%0d cnt=%0d",
                               i, buf_out, fifo_counter, exp_out, model_cnt);
         end
      end
   endtask

   task automatic test_mid_reset();
      while (model_cnt > 10) step(1'b0, 1'b1, 8'd0);
      while (model_cnt < 10) step(1'b1, 1'b0, 8'(8'hC0 + model_cnt));
      checks++;
      if (fifo_counter !== 8'd10) begin
         errors++; $display("FAIL midrst_pre: got %0d expected 10", fifo_counter);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (fifo_counter !== 8'd0 || buf_empty !== 1'b1 || buf_full !== 1'b0 || buf_out !== 8'd0)
      begin
         errors++; $display("FAIL midrst_now: got cnt=%0d empty=%b full=%b out=%0d expected 0/1/0/0",
                            fifo_counter, buf_empty, buf_full, buf_out);
      end
      #1;
      rst = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      exp_out   = 8'd0;
      step(1'b0, 1'b1, 8'd0);
      checks++;
      if (buf_out !== 8'd0 || fifo_counter !== 8'd0) begin
         errors++; $display("FAIL midrst_stale: got out=%0d cnt=%0d expected out=0 cnt=0",
                            buf_out, fifo_counter);
      end
      step(1'b1, 1'b0, 8'd77);
      step(1'b0, 1'b1, 8'd0);
      checks++;
      if (buf_out !== 8'd77) begin
         errors++; $display("FAIL midrst_first: got %0d expected 77", buf_out);
      end
   endtask

   initial begin
      wr_en  = 1'b0;
      rd_en  = 1'b0;
      buf_in = 8'd0;
      test_reset();
      test_ordered();
      test_fill();
      test_read_empty();
      test_simultaneous();
      test_wrap();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock, synchronous first-in-first-out byte buffer with registered read data, full/empty flags and an occupancy counter.
- Sits between a producer and a consumer in the same clock domain, decoupling bursty writes from reads.
- Storage is a circular buffer addressed by independent write and read pointers.

Parameters:
- DATA_WIDTH, 8, width of buf_in/buf_out in bits
- DEPTH, 64, number of storage entries (power of two)
- ADDR_WIDTH, 6, pointer width, equal to log2(DEPTH)
- CNT_WIDTH, 8, width of fifo_counter; must be able to represent DEPTH

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- buf_in  input  DATA_WIDTH  write data
- buf_out  output  DATA_WIDTH  registered read data
- wr_en  input  1  write request
- rd_en  input  1  read request
- buf_empty  output  1  high when fifo_counter == 0
- buf_full  output  1  high when fifo_counter == DEPTH
- fifo_counter  output  CNT_WIDTH  number of entries currently stored

Behaviour:
- One clock. Reset is asynchronous and active-low: rst low immediately clears state, independent of clk.
- Values while rst is low:
  - wr_ptr = 0, rd_ptr = 0
  - fifo_counter = 0, buf_out = 0
  - buf_empty = 1, buf_full = 0
  - Memory contents are not cleared.
- Flags are combinational decodes of fifo_counter. There is no separate flag register.
- Write:
  - Accepted when wr_en=1 and buf_full=0.
  - mem[wr_ptr] <= buf_in and wr_ptr increments, both on the rising edge.
  - Otherwise the write is silently dropped: no pointer or memory change.
- Read:
  - Accepted when rd_en=1 and buf_empty=0.
  - buf_out <= mem[rd_ptr] and rd_ptr increments on the rising edge.
  - Data is valid after the edge (1-cycle latency).
  - When no read is accepted, buf_out holds its previous value.
- Pointers wrap modulo DEPTH (natural ADDR_WIDTH rollover).
- Counter update per edge:
  - Write only accepted: +1
  - Read only accepted: -1
  - Both accepted: unchanged
  - Neither accepted: unchanged
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both operations occur and the counter is unchanged.
  - Empty: only the write occurs, the read is ignored (no fall-through), counter becomes 1.
  - Full: only the read occurs, the write is ignored, counter becomes DEPTH-1.
- Reads from empty and writes to full are ignored without error. fifo_counter never underflows or overflows.
- Reset asserted mid-operation discards all stored entries. The first read after reset returns the first word written after reset.
- No X propagation from uninitialised memory: reads are only permitted when not empty.

Decomposition:
- Shared package fifo_pkg holds DATA_WIDTH, DEPTH, ADDR_WIDTH and CNT_WIDTH defaults, plus a helper constant for the full count (DEPTH).
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH synchronous-write array with a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata).
- The top level holds the pointers, counter, flag decode and accept logic.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> fifo_counter=0, buf_empty=1, buf_full=0, buf_out=0, applied immediately without a clock edge.
- Ordered write then read:
  - Write 100, 150, 175, 200 on four edges -> fifo_counter=4, buf_empty=0.
  - Then read four edges -> buf_out = 100, 150, 175, 200 on successive edges; counter reaches 0 and buf_empty=1.
- Fill to full:
  - Write values 0..63 -> buf_full=1, fifo_counter=64.
  - 65th write of 0xAA -> ignored, counter stays 64.
  - Draining 64 reads returns 0..63 in order.
- Read from empty: rd_en=1 for 3 edges after reset -> buf_out stays 0, counter stays 0, no pointer movement; a subsequent write of 225 then a read returns 225.
- Simultaneous ops:
  - Counter=2 with wr_en=rd_en=1 -> counter stays 2 and the oldest word is output.
  - Empty with both enabled -> counter becomes 1 and buf_out unchanged.
  - Full with both enabled -> counter becomes 63.
- Wrap-around and mid-operation reset:
  - 100 cycles of interleaved write/read -> data order preserved across pointer wrap.
  - Asserting rst low while holding 10 entries -> counter=0 immediately; stored data is not readable.
